// File: rtl/rc4_prga_decrypt_pkg.sv
// rc4_pkg: shared FSM states and plaintext character rules for the RC4 decrypt stage.
package rc4_pkg;
  typedef enum logic [4:0] {
    IDLE, INC, RD_I, WT_I, GET_I, RD_J, WT_J, GET_J, WR_I, SET_J, WR_J,
    RD_F, WT_F, DEC, WR_D, NEXT, DONE
  } state_e;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LO = 8'h61;
  localparam logic [7:0] ASCII_HI = 8'h7A;
  function automatic logic is_valid_char(input logic [7:0] b);
    return (b == ASCII_SPACE) || (b >= ASCII_LO && b <= ASCII_HI);
  endfunction
endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// rc4_prga_decrypt_if: control handshake plus working RAM, cipher ROM and plaintext RAM ports.
interface rc4_prga_decrypt_if #(parameter int AW = 5);
  logic start, done_ack, busy, done, pass;
  logic [7:0] s_addr, s_wdata, s_q;
  logic s_wren;
  logic [AW-1:0] c_addr, d_addr;
  logic [7:0] c_q, d_wdata;
  logic d_wren;
  modport master (
    output start, done_ack, s_q, c_q,
    input busy, done, pass, s_addr, s_wdata, s_wren, c_addr, d_addr, d_wdata, d_wren
  );
  modport slave (
    input start, done_ack, s_q, c_q,
    output busy, done, pass, s_addr, s_wdata, s_wren, c_addr, d_addr, d_wdata, d_wren
  );
endinterface

// File: rtl/rc4_prga_decrypt_char_check.sv
// rc4_char_check: combinational plaintext validity test (space or lowercase letter).
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] ch_i,
  output logic       valid_o
);
  assign valid_o = is_valid_char(ch_i);
endmodule

// File: rtl/rc4_prga_decrypt.sv
// rc4_prga_decrypt: RC4 PRGA over a pre-scheduled S box, XOR-decrypts the cipher ROM into the plaintext RAM.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter bit CHECK_EN = 1'b1,
  parameter int AW = $clog2(MSG_LEN)
) (
  input logic clk,
  input logic rst,
  rc4_prga_decrypt_if.slave bus
);
  state_e state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d, si_q, si_d, sj_q, sj_d;
  logic [7:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d, d_wdata_q, d_wdata_d;
  logic [AW-1:0] c_addr_q, c_addr_d, d_addr_q, d_addr_d;
  logic pass_q, pass_d, valid;
  logic [7:0] pt;
  assign pt = bus.s_q ^ bus.c_q;
  rc4_char_check u_chk (.ch_i(pt), .valid_o(valid));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      si_q <= '0;
      sj_q <= '0;
      s_addr_q <= '0;
      s_wdata_q <= '0;
      d_wdata_q <= '0;
      c_addr_q <= '0;
      d_addr_q <= '0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
      si_q <= si_d;
      sj_q <= sj_d;
      s_addr_q <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      d_wdata_q <= d_wdata_d;
      c_addr_q <= c_addr_d;
      d_addr_q <= d_addr_d;
      pass_q <= pass_d;
    end
  end
  // Swap S[i]/S[j] then fetch S[S[i]+S[j]]; every read waits one state for the synchronous RAM.
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    si_d = si_q;
    sj_d = sj_q;
    s_addr_d = s_addr_q;
    s_wdata_d = s_wdata_q;
    d_wdata_d = d_wdata_q;
    c_addr_d = c_addr_q;
    d_addr_d = d_addr_q;
    pass_d = pass_q;
    case (state_q)
      IDLE: if (bus.start) begin
        i_d = '0;
        j_d = '0;
        k_d = '0;
        pass_d = 1'b0;
        state_d = INC;
      end
      INC: begin
        i_d = i_q + 8'd1;
        state_d = RD_I;
      end
      RD_I: begin
        s_addr_d = i_q;
        state_d = WT_I;
      end
      WT_I: state_d = GET_I;
      GET_I: begin
        si_d = bus.s_q;
        j_d = j_q + bus.s_q;
        state_d = RD_J;
      end
      RD_J: begin
        s_addr_d = j_q;
        state_d = WT_J;
      end
      WT_J: state_d = GET_J;
      GET_J: begin
        sj_d = bus.s_q;
        s_addr_d = i_q;
        s_wdata_d = bus.s_q;
        state_d = WR_I;
      end
      WR_I: state_d = SET_J;
      SET_J: begin
        s_addr_d = j_q;
        s_wdata_d = si_q;
        state_d = WR_J;
      end
      WR_J: state_d = RD_F;
      RD_F: begin
        s_addr_d = si_q + sj_q;
        c_addr_d = k_q[AW-1:0];
        state_d = WT_F;
      end
      WT_F: state_d = DEC;
      DEC: begin
        d_addr_d = k_q[AW-1:0];
        d_wdata_d = pt;
        state_d = (CHECK_EN && !valid) ? DONE : WR_D;
      end
      WR_D: state_d = NEXT;
      NEXT: begin
        pass_d = (k_q == 8'(MSG_LEN - 1)) ? 1'b1 : pass_q;
        k_d = (k_q == 8'(MSG_LEN - 1)) ? k_q : k_q + 8'd1;
        state_d = (k_q == 8'(MSG_LEN - 1)) ? DONE : INC;
      end
      DONE: state_d = bus.done_ack ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.pass = pass_q;
  assign bus.s_addr = s_addr_q;
  assign bus.s_wdata = s_wdata_q;
  assign bus.s_wren = (state_q == WR_I) || (state_q == WR_J);
  assign bus.c_addr = c_addr_q;
  assign bus.d_addr = d_addr_q;
  assign bus.d_wdata = d_wdata_q;
  assign bus.d_wren = state_q == WR_D;
endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// tb_rc4_prga_decrypt: two DUTs (check off/on) with RAM/ROM models, checked against a plain RC4 reference.
module tb_rc4_prga_decrypt;
  localparam int L = 4;
  localparam int AW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] ld = 2'b00;
  always #5 clk = ~clk;
  rc4_prga_decrypt_if #(.AW(AW)) b0 ();
  rc4_prga_decrypt_if #(.AW(AW)) b1 ();
  rc4_prga_decrypt #(.MSG_LEN(L), .CHECK_EN(1'b0), .AW(AW)) u0 (.clk(clk), .rst(rst), .bus(b0));
  rc4_prga_decrypt #(.MSG_LEN(L), .CHECK_EN(1'b1), .AW(AW)) u1 (.clk(clk), .rst(rst), .bus(b1));
  logic [7:0] sm [2][256];
  logic [7:0] init_s [2][256];
  logic [7:0] dm [2][L];
  logic [7:0] init_d [2][L];
  logic [7:0] cm [2][L];
  logic [7:0] xs [256];
  logic [7:0] xd [L];
  logic [7:0] xks [L];
  int xab;
  int n_chk = 0;
  int n_pass = 0;
  always @(posedge clk) begin
    if (ld[0]) begin
      for (int a = 0; a < 256; a++) sm[0][a] <= init_s[0][a];
      for (int a = 0; a < L; a++) dm[0][a] <= init_d[0][a];
    end else begin
      if (b0.s_wren) sm[0][b0.s_addr] <= b0.s_wdata;
      if (b0.d_wren) dm[0][b0.d_addr] <= b0.d_wdata;
    end
    b0.s_q <= sm[0][b0.s_addr];
    b0.c_q <= cm[0][b0.c_addr];
  end
  always @(posedge clk) begin
    if (ld[1]) begin
      for (int a = 0; a < 256; a++) sm[1][a] <= init_s[1][a];
      for (int a = 0; a < L; a++) dm[1][a] <= init_d[1][a];
    end else begin
      if (b1.s_wren) sm[1][b1.s_addr] <= b1.s_wdata;
      if (b1.d_wren) dm[1][b1.d_addr] <= b1.d_wdata;
    end
    b1.s_q <= sm[1][b1.s_addr];
    b1.c_q <= cm[1][b1.c_addr];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  function automatic logic [4:0] st(input int u);
    return u != 0 ? {b1.busy, b1.done, b1.pass, b1.s_wren, b1.d_wren}
                  : {b0.busy, b0.done, b0.pass, b0.s_wren, b0.d_wren};
  endfunction
  task automatic drv(input int u, input logic s, input logic a);
    if (u != 0) begin
      b1.start = s;
      b1.done_ack = a;
    end else begin
      b0.start = s;
      b0.done_ack = a;
    end
  endtask
  function automatic bit ok(input logic [7:0] p);
    return p == 8'h20 || (p >= 8'h61 && p <= 8'h7a);
  endfunction
  task automatic load(input int u);
    @(negedge clk);
    ld[u] = 1'b1;
    @(negedge clk);
    ld[u] = 1'b0;
  endtask
  task automatic ident(input int u);
    for (int a = 0; a < 256; a++) init_s[u][a] = 8'(a);
  endtask
  task automatic perm(input int u);
    logic [7:0] t;
    int b;
    ident(u);
    for (int a = 255; a > 0; a--) begin
      b = $urandom_range(0, a);
      t = init_s[u][a];
      init_s[u][a] = init_s[u][b];
      init_s[u][b] = t;
    end
  endtask
  // Textbook RC4 PRGA on plain arrays; xab is the aborting byte or -1.
  task automatic model(input int u, input bit chk);
    int i, j;
    logic [7:0] t, p;
    i = 0;
    j = 0;
    xab = -1;
    for (int a = 0; a < 256; a++) xs[a] = init_s[u][a];
    for (int k = 0; k < L; k++) xd[k] = init_d[u][k];
    for (int k = 0; k < L; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(xs[i])) % 256;
      t = xs[i];
      xs[i] = xs[j];
      xs[j] = t;
      xks[k] = xs[(int'(xs[i]) + int'(xs[j])) % 256];
      p = xks[k] ^ cm[u][k];
      if (chk && !ok(p)) begin
        xab = k;
        break;
      end
      xd[k] = p;
    end
  endtask
  task automatic run(input int u, input bit noisy, output int edges, output int nwr, output logic pf);
    logic [4:0] v;
    logic psw, pdw;
    psw = 1'b0;
    pdw = 1'b0;
    @(negedge clk);
    drv(u, 1'b1, 1'b0);
    @(posedge clk);
    edges = 1;
    nwr = 0;
    @(negedge clk);
    v = st(u);
    while (!v[3] && edges < 20 * L + 50) begin
      if (v[1]) check("s_wren_width", 32'(psw), 0);
      if (v[0]) begin
        check("d_wren_width", 32'(pdw), 0);
        nwr++;
      end
      psw = v[1];
      pdw = v[0];
      drv(u, noisy ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
      @(posedge clk);
      edges++;
      @(negedge clk);
      v = st(u);
    end
    check("done_seen", 32'(v[3]), 1);
    pf = v[2];
    repeat ($urandom_range(1, 3)) begin
      drv(u, noisy ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      v = st(u);
      check("done_hold", 32'(v[3]), 1);
    end
    drv(u, noisy ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drv(u, 1'b0, 1'b0);
    v = st(u);
    check("idle_after_ack", 32'(v[4:3]), 0);
  endtask
  task automatic judge(input int u, input int edges, input int nwr, input logic pf);
    int e;
    e = 0;
    check("done_edge", edges, xab < 0 ? 15 * L + 1 : 15 * xab + 14);
    check("pass", 32'(pf), xab < 0 ? 1 : 0);
    check("d_writes", nwr, xab < 0 ? L : xab);
    for (int k = 0; k < L; k++) check($sformatf("d_byte%0d", k), 32'(dm[u][k]), 32'(xd[k]));
    for (int a = 0; a < 256; a++) if (sm[u][a] !== xs[a]) e++;
    check("s_final", e, 0);
  endtask
  initial begin
    int ed, nw;
    logic pf;
    logic [7:0] keep [L];
    logic [7:0] pt;
    logic [7:0] aaaa [L];
    logic [7:0] c_a [L];
    c_a = '{8'h63, 8'h64, 8'h66, 8'h6c};
    aaaa = '{8'h61, 8'h61, 8'h61, 8'h61};
    drv(0, 1'b0, 1'b0);
    drv(1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_status0", 32'(st(0)), 0);
    check("rst_status1", 32'(st(1)), 0);
    check("rst_bus0", {b0.s_addr, b0.s_wdata, b0.d_wdata, 2'(b0.c_addr), 2'(b0.d_addr)}, 0);
    rst = 1'b0;
    // identity S, zero cipher, no check: keystream 02,05,07,0D
    ident(0);
    for (int k = 0; k < L; k++) begin
      cm[0][k] = 8'h00;
      init_d[0][k] = 8'hee;
    end
    load(0);
    model(0, 1'b0);
    run(0, 1'b0, ed, nw, pf);
    judge(0, ed, nw, pf);
    check("ks_const0", {dm[0][0], dm[0][1], dm[0][2], dm[0][3]}, 32'h0205070d);
    check("s_const", {sm[0][2], sm[0][3], sm[0][5]}, 24'h030502);
    // checked unit, plaintext "aaaa"
    ident(1);
    for (int k = 0; k < L; k++) begin
      cm[1][k] = c_a[k];
      init_d[1][k] = 8'hee;
    end
    load(1);
    model(1, 1'b1);
    run(1, 1'b0, ed, nw, pf);
    judge(1, ed, nw, pf);
    for (int k = 0; k < L; k++) check("aaaa", 32'(dm[1][k]), 32'(aaaa[k]));
    // checked unit, first byte invalid: abort at k=0
    ident(1);
    for (int k = 0; k < L; k++) begin
      cm[1][k] = 8'h00;
      init_d[1][k] = 8'h5a;
    end
    load(1);
    model(1, 1'b1);
    run(1, 1'b1, ed, nw, pf);
    judge(1, ed, nw, pf);
    check("abort_edge", ed, 14);
    // back-to-back reruns from the same S must reproduce D
    ident(0);
    for (int k = 0; k < L; k++) begin
      cm[0][k] = 8'($urandom);
      init_d[0][k] = 8'h11;
    end
    load(0);
    model(0, 1'b0);
    run(0, 1'b1, ed, nw, pf);
    judge(0, ed, nw, pf);
    for (int k = 0; k < L; k++) keep[k] = dm[0][k];
    for (int k = 0; k < L; k++) init_d[0][k] = 8'h22;
    load(0);
    model(0, 1'b0);
    run(0, 1'b1, ed, nw, pf);
    judge(0, ed, nw, pf);
    for (int k = 0; k < L; k++) check("rerun_d", 32'(dm[0][k]), 32'(keep[k]));
    // reset during WR_I of byte 2 (state entered at edge 38)
    load(0);
    @(negedge clk);
    drv(0, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drv(0, 1'b0, 1'b0);
    repeat (37) @(posedge clk);
    @(negedge clk);
    check("wr_i_reached", 32'(st(0)), 5'b10010);
    rst = 1'b1;
    #1;
    check("rst_mid_run", 32'(st(0)), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < L; k++) init_d[0][k] = 8'h33;
    load(0);
    model(0, 1'b0);
    run(0, 1'b0, ed, nw, pf);
    judge(0, ed, nw, pf);
    // random S and cipher; checked unit gets mostly-valid plaintext with an occasional bad byte
    for (int r = 0; r < 10; r++) begin
      int u;
      u = r % 2;
      perm(u);
      for (int k = 0; k < L; k++) init_d[u][k] = 8'($urandom);
      if (u == 0) begin
        for (int k = 0; k < L; k++) cm[0][k] = 8'($urandom);
      end else begin
        model(1, 1'b0);
        for (int k = 0; k < L; k++) begin
          pt = ($urandom_range(0, 26) == 0) ? 8'h20 : 8'(8'h61 + $urandom_range(0, 25));
          if ($urandom_range(0, 5) == 0) pt = 8'($urandom_range(0, 31));
          cm[1][k] = xks[k] ^ pt;
        end
      end
      load(u);
      model(u, u != 0);
      run(u, 1'b1, ed, nw, pf);
      judge(u, ed, nw, pf);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rc4_prga_decrypt.md
# rc4_prga_decrypt

Parametrised RC4 keystream generator and decryptor: consumes an already key-scheduled S permutation in the 256×8 working RAM, swaps entries per RC4 PRGA, XORs the keystream with an encrypted-message ROM of MSG_LEN bytes and writes plaintext to the decrypted RAM. Sits after the key-schedule stage in the decryption pipeline. Adds an optional plaintext validity check with early abort and a pass/fail result, for key search, and clears its indices on every start so it can be rerun.

## Interface
- MSG_LEN, 32: message length in bytes (2..256).
- CHECK_EN, 1: 1 = abort on first invalid plaintext byte; 0 = never abort.
- AW, $clog2(MSG_LEN): address width for message ROM and decrypted RAM.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request run; sampled only in IDLE.
- done_ack  in  1  releases DONE.
- busy  out  1  high in every state except IDLE.
- done  out  1  high only in DONE.
- pass  out  1  result; valid while done=1.
- s_addr  out  8  working RAM address.
- s_wdata  out  8  working RAM write data.
- s_wren  out  1  working RAM write enable.
- s_q  in  8  working RAM read data.
- c_addr  out  AW  encrypted ROM address.
- c_q  in  8  encrypted ROM read data.
- d_addr  out  AW  decrypted RAM address.
- d_wdata  out  8  decrypted RAM write data.
- d_wren  out  1  decrypted RAM write enable.

## Operation
- Reset: state IDLE. All outputs 0, including pass. Indices i, j, k are 0.
- Start is sampled in IDLE. It clears i, j, k and pass and enters INC.
- Per byte k, 15 states, 8-bit mod-256 arithmetic:
  - INC: i<=i+1.
  - RD_I: s_addr<=i.
  - WT_I: wait.
  - GET_I: si<=s_q; j<=j+s_q.
  - RD_J: s_addr<=j.
  - WT_J: wait.
  - GET_J: sj<=s_q; s_addr<=i; s_wdata<=s_q.
  - WR_I: s_wren=1.
  - SET_J: s_addr<=j; s_wdata<=si.
  - WR_J: s_wren=1.
  - RD_F: s_addr<=si+sj; c_addr<=k.
  - WT_F: wait.
  - DEC: d<=s_q^c_q; d_addr<=k; d_wdata<=s_q^c_q; evaluate the check.
  - WR_D: d_wren=1.
  - NEXT: if k==MSG_LEN-1, set pass<=1 and go to DONE; else k<=k+1 and go to INC.
- Valid byte: 0x20, or 0x61..0x7A.
- Abort: if CHECK_EN=1 and the byte formed in DEC is invalid, go DEC→DONE with pass=0. The invalid byte is not written (no WR_D).
- i==j: both writes go to the same address with the same value, so S is unchanged. No special case.
- DONE holds until done_ack=1, then goes to IDLE. In DONE, start is ignored.
- start while busy is ignored. done_ack outside DONE is ignored.
- Unreachable state encoding → IDLE.
- rst mid-run: immediate return to IDLE with all enables 0. RAM contents are left as they are.

## Timing
- Memories use synchronous reads. Data for an address registered in state X is sampled two states later (the WT_* state sits between them).
- s_wren and d_wren are each high for exactly one cycle. Address and data are registered one state earlier and held through the write cycle.
- Full run: done rises 15·MSG_LEN+1 rising edges after the edge that samples start.
- Abort at byte k: done rises 15·k+14 edges after start.
- Outputs are registered or decoded directly from state. There is no combinational path from inputs to outputs.
- DONE→IDLE takes 1 cycle after done_ack. The earliest restart is the start sampled on the next edge.

## Structure
- Package rc4_pkg:
  - state enum typedef;
  - constants ASCII_SPACE=8'h20, ASCII_LO=8'h61, ASCII_HI=8'h7A;
  - function is_valid_char(byte).
- Sub-module rc4_char_check: combinational validity check, instantiated once and shared with future key-search blocks.
- The FSM and datapath stay in one module. The enum is sequential; wren/done are decoded from the state.

## Test plan
- S identity (S[x]=x), C=00,00,00,00, MSG_LEN=4, CHECK_EN=0 → D=02,05,07,0D; pass=1; done at edge 61; S[2]=3, S[3]=5, S[5]=2.
- Same S, C=63,64,66,6C, CHECK_EN=1 → D="aaaa"; pass=1.
- Same S, C=00.., CHECK_EN=1 → abort at k=0: done at edge 14, pass=0, no d_wren pulse, D untouched.
- Two back-to-back runs with S reloaded to identity, and done_ack held high for 1 cycle between them → identical D both runs (indices cleared); start pulses during a run are ignored.
- rst asserted during WR_I of byte 2 → state IDLE, all enables 0 within the same cycle; a new start runs normally.
- Protocol checks on every run: each wren pulse is 1 cycle wide, and done stays high until done_ack.
